// File: rtl/moore_seq_detector_if.sv
// Bundle of the serial bit stream, clear strobe and detector status.
// en is a valid strobe with no back-pressure: inp is taken on every rising edge where en=1.
interface moore_seq_detector_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    localparam int SW = $clog2(N + 1);

    logic             en;
    logic             inp;
    logic             clr;
    logic             out;
    logic [SW-1:0]    state;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (output en, inp, clr, input out, state, match_cnt, cnt_sat);
    modport slave  (input en, inp, clr, output out, state, match_cnt, cnt_sat);
endinterface

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with KMP fallback, optional overlap,
// enable qualifier and a saturating match counter.
module moore_seq_detector #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1011,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CNT_W   = 8
) (
    input logic                 clk,
    input logic                 rst,
    moore_seq_detector_if.slave bus
);
    localparam int               SW      = $clog2(N + 1);
    localparam logic [SW-1:0]    S_MATCH = SW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Length of the longest suffix of (first k pattern bits, then b) that is
    // also a pattern prefix, capped at N. Evaluated only at elaboration.
    function automatic int border_len(input int k, input logic b);
        int pat;
        int seqv;
        int best;
        bit ok;
        pat  = int'(PATTERN);
        seqv = 0;
        best = 0;
        for (int i = 0; i < k; i++)
            seqv = seqv | (((pat >> (N - 1 - i)) & 1) << i);
        seqv = seqv | (int'(b) << k);
        for (int j = 1; j <= N; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++)
                    if (((seqv >> (k + 1 - j + i)) & 1) != ((pat >> (N - 1 - i)) & 1))
                        ok = 1'b0;
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    logic [SW-1:0] nxt0_tbl [N+1];
    logic [SW-1:0] nxt1_tbl [N+1];

    // Without overlap, leaving the match state behaves exactly like leaving S0.
    for (genvar gk = 0; gk <= N; gk++) begin : g_row
        localparam int            KF   = (gk == N && !OVERLAP) ? 0 : gk;
        localparam logic [SW-1:0] NXT0 = SW'(border_len(KF, 1'b0));
        localparam logic [SW-1:0] NXT1 = SW'(border_len(KF, 1'b1));
        assign nxt0_tbl[gk] = NXT0;
        assign nxt1_tbl[gk] = NXT1;
    end

    logic [SW-1:0]    state_q;
    logic [SW-1:0]    fsm_nxt;
    logic [SW-1:0]    state_nxt;
    logic             state_legal;
    logic             match_next;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;

    always_comb begin
        fsm_nxt = '0;
        for (int k = 0; k <= N; k++)
            if (state_q == SW'(k))
                fsm_nxt = bus.inp ? nxt1_tbl[k] : nxt0_tbl[k];
    end

    assign state_legal = (state_q <= S_MATCH);
    assign state_nxt   = !state_legal ? '0 : (bus.en ? fsm_nxt : state_q);
    assign match_next  = bus.en && state_legal && (fsm_nxt == S_MATCH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (bus.clr) begin
                cnt_q <= '0;
                sat_q <= 1'b0;
            end else if (match_next && !sat_q) begin
                cnt_q <= cnt_q + CNT_W'(1);
                sat_q <= (cnt_q == CNT_MAX - CNT_W'(1));
            end
        end
    end

    assign bus.state     = state_q;
    assign bus.out       = (state_q == S_MATCH);
    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = sat_q;
endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector: three instances (overlap, no overlap,
// N=1 with a 2-bit counter) checked against a history-based model every cycle.
module tb_moore_seq_detector;
    logic clk;
    logic rst;

    moore_seq_detector_if #(.N(4), .CNT_W(8)) if_a ();
    moore_seq_detector_if #(.N(4), .CNT_W(8)) if_b ();
    moore_seq_detector_if #(.N(1), .CNT_W(2)) if_c ();

    moore_seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8))
        u_a (.clk(clk), .rst(rst), .bus(if_a));
    moore_seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8))
        u_b (.clk(clk), .rst(rst), .bus(if_b));
    moore_seq_detector #(.N(1), .PATTERN(1'b1), .OVERLAP(1'b1), .CNT_W(2))
        u_c (.clk(clk), .rst(rst), .bus(if_c));

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    // clock / reset
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: detector state is the longest suffix of accepted history that is a pattern prefix
    function automatic int match_len(input bit h[$], input int pat, input int n);
        int best = 0;
        for (int j = 1; j <= n; j++) begin
            bit ok;
            if (j > h.size()) break;
            ok = 1;
            for (int i = 0; i < j; i++)
                if (int'(h[h.size() - j + i]) != ((pat >> (n - 1 - i)) & 1)) ok = 0;
            if (ok) best = j;
        end
        return best;
    endfunction

    task automatic cnt_update(input bit clr, input bit hit, input int max,
                              inout int cnt, inout bit sat);
        if (clr) begin
            cnt = 0;
            sat = 0;
        end else if (hit) begin
            if (cnt < max) cnt = cnt + 1;
            sat = (cnt == max);
        end
    endtask

    bit ha[$];
    bit hb[$];
    bit hc[$];
    int sa, sb, sc, ca, cb, cc;
    bit ta, tb_s, tc;

    initial begin
        sa = 0; sb = 0; sc = 0; ca = 0; cb = 0; cc = 0; ta = 0; tb_s = 0; tc = 0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                ha.delete(); hb.delete(); hc.delete();
                sa = 0; sb = 0; sc = 0; ca = 0; cb = 0; cc = 0;
                ta = 0; tb_s = 0; tc = 0;
            end else begin
                if (if_a.en) begin
                    ha.push_back(if_a.inp);
                    if (ha.size() > 4) void'(ha.pop_front());
                    sa = match_len(ha, 'b1011, 4);
                end
                cnt_update(if_a.clr, if_a.en && sa == 4, 255, ca, ta);
                if (if_b.en) begin
                    if (sb == 4) hb.delete();
                    hb.push_back(if_b.inp);
                    if (hb.size() > 4) void'(hb.pop_front());
                    sb = match_len(hb, 'b1011, 4);
                end
                cnt_update(if_b.clr, if_b.en && sb == 4, 255, cb, tb_s);
                if (if_c.en) begin
                    hc.push_back(if_c.inp);
                    if (hc.size() > 1) void'(hc.pop_front());
                    sc = match_len(hc, 'b1, 1);
                end
                cnt_update(if_c.clr, if_c.en && sc == 1, 3, cc, tc);
            end
        end
    end

    // scoreboard compare on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                check("a_state", int'(if_a.state), sa);
                check("a_out", int'(if_a.out), int'(sa == 4));
                check("a_cnt", int'(if_a.match_cnt), ca);
                check("a_sat", int'(if_a.cnt_sat), int'(ta));
                check("b_state", int'(if_b.state), sb);
                check("b_out", int'(if_b.out), int'(sb == 4));
                check("b_cnt", int'(if_b.match_cnt), cb);
                check("b_sat", int'(if_b.cnt_sat), int'(tb_s));
                check("c_state", int'(if_c.state), sc);
                check("c_out", int'(if_c.out), int'(sc == 1));
                check("c_cnt", int'(if_c.match_cnt), cc);
                check("c_sat", int'(if_c.cnt_sat), int'(tc));
            end
        end
    end

    // driver tasks
    task automatic step_ab(input bit e, input bit d);
        if_a.en = e; if_a.inp = d; if_a.clr = 0;
        if_b.en = e; if_b.inp = d; if_b.clr = 0;
        if_c.en = 0; if_c.inp = 0; if_c.clr = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic step_c(input bit e, input bit d, input bit c);
        if_a.en = 0; if_a.inp = 0; if_a.clr = 0;
        if_b.en = 0; if_b.inp = 0; if_b.clr = 0;
        if_c.en = e; if_c.inp = d; if_c.clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_a.en = 0; if_a.inp = 0; if_a.clr = 0;
        if_b.en = 0; if_b.inp = 0; if_b.clr = 0;
        if_c.en = 0; if_c.inp = 0; if_c.clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    bit t1_bits[4] = '{1, 0, 1, 1};
    int t1_st[4]   = '{1, 2, 3, 4};
    bit t2_bits[7] = '{1, 0, 1, 1, 0, 1, 1};
    int t2_out[7]  = '{0, 0, 0, 1, 0, 0, 1};
    bit t3_bits[6] = '{1, 0, 1, 0, 1, 1};
    int t3_st[6]   = '{1, 2, 3, 2, 3, 4};
    bit t5_bits[7] = '{1, 0, 1, 1, 1, 0, 1};
    int t6_cnt[5]  = '{1, 2, 3, 3, 3};
    int t6_sat[5]  = '{0, 0, 1, 1, 1};

    initial begin
        idle_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", int'(if_a.state), 0);
        check("rst_out", int'(if_a.out), 0);
        check("rst_cnt", int'(if_a.match_cnt), 0);
        rst = 1;
        chk_on = 1;
        @(posedge clk);
        #1;

        // basic match
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step_ab(1, t1_bits[i]);
            check($sformatf("t1_state%0d", i), int'(if_a.state), t1_st[i]);
            if (i == 2) check("t1_out_early", int'(if_a.out), 0);
        end
        check("t1_out", int'(if_a.out), 1);
        check("t1_cnt", int'(if_a.match_cnt), 1);

        // overlap vs restart
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step_ab(1, t2_bits[i]);
            check($sformatf("t2_out%0d", i), int'(if_a.out), t2_out[i]);
        end
        check("t2_cnt_ov", int'(if_a.match_cnt), 2);
        check("t2_cnt_nov", int'(if_b.match_cnt), 1);
        check("t2_state_nov", int'(if_b.state), 1);

        // KMP fallback
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step_ab(1, t3_bits[i]);
            check($sformatf("t3_state%0d", i), int'(if_a.state), t3_st[i]);
        end
        check("t3_cnt", int'(if_a.match_cnt), 1);

        // enable gaps
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step_ab(1, t1_bits[i]);
            for (int g = 0; g < 3; g++) begin
                step_ab(0, ~t1_bits[i]);
                check($sformatf("t4_hold%0d_%0d", i, g), int'(if_a.state), t1_st[i]);
                if (i == 3) check($sformatf("t4_out_hold%0d", g), int'(if_a.out), 1);
            end
        end
        check("t4_cnt", int'(if_a.match_cnt), 1);
        step_ab(1, 0);
        check("t4_after", int'(if_a.state), 2);

        // asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 7; i++) step_ab(1, t5_bits[i]);
        check("t5_pre_state", int'(if_a.state), 3);
        check("t5_pre_cnt", int'(if_a.match_cnt), 1);
        idle_inputs();
        #2;
        rst = 0;
        #1;
        check("t5_async_state", int'(if_a.state), 0);
        check("t5_async_out", int'(if_a.out), 0);
        check("t5_async_cnt", int'(if_a.match_cnt), 0);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) step_ab(1, t1_bits[i]);
        check("t5_resume_out", int'(if_a.out), 1);
        check("t5_resume_cnt", int'(if_a.match_cnt), 1);

        // saturation and clear on the N=1 instance
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step_c(1, 1, 0);
            check($sformatf("t6_cnt%0d", i), int'(if_c.match_cnt), t6_cnt[i]);
            check($sformatf("t6_sat%0d", i), int'(if_c.cnt_sat), t6_sat[i]);
            check($sformatf("t6_out%0d", i), int'(if_c.out), 1);
        end
        step_c(1, 1, 1);
        check("t6_clr_cnt", int'(if_c.match_cnt), 0);
        check("t6_clr_sat", int'(if_c.cnt_sat), 0);
        check("t6_clr_out", int'(if_c.out), 1);
        step_c(1, 1, 0);
        check("t6_post_clr_cnt", int'(if_c.match_cnt), 1);
        step_c(1, 0, 0);
        check("t6_zero_out", int'(if_c.out), 0);
        step_c(0, 0, 0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
